// File: rtl/jzjpcc_mem_pkg.sv
// Shared types and helpers for the load/store sequencer.
package jzjpcc_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_RESP  = 2'd3
    } mem_state_t;

    // funct3[1:0] access-size encodings
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    // Byte count of an access: 1, 2, 4 or 8.
    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/jzjpcc_mem_lane_formatter.sv
// Combinational lane formatter: places an n-byte value starting at word
// offset off across two consecutive bus words, in bus lane order.
module jzjpcc_mem_lane_formatter
    import jzjpcc_mem_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int BYTES = XLEN / 8,
    parameter int OFF   = $clog2(XLEN / 8)
) (
    input  logic [OFF-1:0]   i_off,
    input  logic [1:0]       i_size,
    input  logic [XLEN-1:0]  i_value,
    output logic [BYTES-1:0] o_mask0,
    output logic [BYTES-1:0] o_mask1,
    output logic [XLEN-1:0]  o_wdata0,
    output logic [XLEN-1:0]  o_wdata1,
    output logic             o_split
);

    // Little-endian view: byte j of the two-word window lives at bits [8j+:8].
    logic [2*BYTES-1:0] w_lmask;
    logic [2*XLEN-1:0]  w_ldata;
    logic [4:0]         w_end;

    assign w_lmask = (((2*BYTES)'(1) << size_bytes(i_size)) - (2*BYTES)'(1)) << i_off;
    assign w_ldata = (2*XLEN)'(i_value) << {i_off, 3'b000};
    assign w_end   = 5'(i_off) + 5'(size_bytes(i_size));
    assign o_split = (w_end > 5'(BYTES));

    // Byte-swap each half into bus order: offset k sits at the MSB end.
    always_comb begin
        o_mask0  = '0;
        o_mask1  = '0;
        o_wdata0 = '0;
        o_wdata1 = '0;
        for (int k = 0; k < BYTES; k++) begin
            o_mask0[BYTES-1-k]          = w_lmask[k];
            o_mask1[BYTES-1-k]          = w_lmask[BYTES+k];
            o_wdata0[XLEN-1-8*k -: 8]   = w_ldata[8*k +: 8];
            o_wdata1[XLEN-1-8*k -: 8]   = w_ldata[XLEN+8*k +: 8];
        end
    end

endmodule

// File: rtl/jzjpcc_mem_sequencer.sv
// Handshaked load/store sequencer: splits misaligned accesses into two
// aligned beats, merges load bytes and sign/zero-extends the result.
module jzjpcc_mem_sequencer
    import jzjpcc_mem_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int ALLOW_MISALIGNED = 1,
    localparam int BYTES           = XLEN / 8,
    localparam int OFF             = $clog2(XLEN / 8)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_address,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_write,
    output logic [31-OFF:0]   mem_address,
    output logic [BYTES-1:0]  mem_byte_mask,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              resp_valid,
    output logic              resp_error,
    output logic [XLEN-1:0]   resp_rdata
);

    mem_state_t       r_state, w_next;
    logic             r_write, r_err;
    logic [2:0]       r_f3;
    logic [OFF-1:0]   r_off;
    logic [XLEN-1:0]  r_wdata, r_rd0, r_rd1, r_mwd;
    logic [31-OFF:0]  r_addr;
    logic [BYTES-1:0] r_mask;

    logic             w_idle, w_fire, w_illegal, w_misal, w_bad;
    logic [OFF-1:0]   w_f_off;
    logic [1:0]       w_f_size;
    logic [XLEN-1:0]  w_f_val, w_wd0, w_wd1;
    logic [BYTES-1:0] w_m0, w_m1;
    logic             w_split;

    assign w_idle = (r_state == ST_IDLE);
    assign w_fire = w_idle && req_valid;

    assign w_illegal = ((req_funct3[1:0] == SZ_D) && (XLEN == 32)) ||
                       (req_funct3[2] && (req_write || (req_funct3[1:0] == SZ_D) ||
                                          ((XLEN == 32) && (req_funct3[1:0] == SZ_W))));
    assign w_misal   = |(req_address[OFF-1:0] & OFF'(size_bytes(req_funct3[1:0]) - 4'd1));
    assign w_bad     = w_illegal || ((ALLOW_MISALIGNED == 0) && w_misal);

    // One formatter: fed by the live request in IDLE, by the captured one after.
    assign w_f_off  = w_idle ? req_address[OFF-1:0] : r_off;
    assign w_f_size = w_idle ? req_funct3[1:0]      : r_f3[1:0];
    assign w_f_val  = w_idle ? req_wdata            : r_wdata;

    jzjpcc_mem_lane_formatter #(.XLEN(XLEN)) u_fmt (
        .i_off    (w_f_off),
        .i_size   (w_f_size),
        .i_value  (w_f_val),
        .o_mask0  (w_m0),
        .o_mask1  (w_m1),
        .o_wdata0 (w_wd0),
        .o_wdata1 (w_wd1),
        .o_split  (w_split)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (req_valid) w_next = w_bad ? ST_RESP : ST_BEAT0;
            ST_BEAT0: if (mem_ready) w_next = w_split ? ST_BEAT1 : ST_RESP;
            ST_BEAT1: if (mem_ready) w_next = ST_RESP;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Request capture, registered beat outputs and read-data latches.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_f3    <= '0;
            r_off   <= '0;
            r_wdata <= '0;
            r_rd0   <= '0;
            r_rd1   <= '0;
            r_addr  <= '0;
            r_mask  <= '0;
            r_mwd   <= '0;
        end else begin
            if (w_fire) begin
                r_write <= req_write;
                r_err   <= w_bad;
                r_f3    <= req_funct3;
                r_off   <= req_address[OFF-1:0];
                r_wdata <= req_wdata;
                if (!w_bad) begin
                    r_addr <= req_address[31:OFF];
                    r_mask <= w_m0;
                    r_mwd  <= req_write ? w_wd0 : '0;
                end
            end else if ((r_state == ST_BEAT0) && mem_ready) begin
                r_rd0 <= mem_rdata;
                if (w_split) begin
                    r_addr <= r_addr + 1'b1;
                    r_mask <= w_m1;
                    r_mwd  <= r_write ? w_wd1 : '0;
                end else begin
                    r_mask <= '0;
                    r_mwd  <= '0;
                end
            end else if ((r_state == ST_BEAT1) && mem_ready) begin
                r_rd1  <= mem_rdata;
                r_mask <= '0;
                r_mwd  <= '0;
            end
        end
    end

    // Load merge: both beats into little-endian order, shift by offset, extend.
    logic [2*XLEN-1:0] w_lin;
    logic [XLEN-1:0]   w_val, w_ext;
    logic              w_sign;
    logic [3:0]        w_n;

    assign w_n = size_bytes(r_f3[1:0]);

    always_comb begin
        w_lin = '0;
        for (int k = 0; k < BYTES; k++) begin
            w_lin[8*k +: 8]      = r_rd0[XLEN-1-8*k -: 8];
            w_lin[XLEN+8*k +: 8] = r_rd1[XLEN-1-8*k -: 8];
        end
        w_val = XLEN'(w_lin >> {r_off, 3'b000});
        case (r_f3[1:0])
            SZ_B:    w_sign = w_val[7];
            SZ_H:    w_sign = w_val[15];
            SZ_W:    w_sign = w_val[31];
            default: w_sign = w_val[XLEN-1];
        endcase
        w_sign = w_sign && !r_f3[2];
        w_ext  = '0;
        for (int k = 0; k < BYTES; k++)
            w_ext[8*k +: 8] = (k < int'(w_n)) ? w_val[8*k +: 8] : {8{w_sign}};
    end

    assign req_ready     = w_idle;
    assign mem_valid     = (r_state == ST_BEAT0) || (r_state == ST_BEAT1);
    assign mem_write     = mem_valid && r_write;
    assign mem_address   = r_addr;
    assign mem_byte_mask = r_mask;
    assign mem_wdata     = r_mwd;
    assign resp_valid    = (r_state == ST_RESP);
    assign resp_error    = resp_valid && r_err;
    assign resp_rdata    = (resp_valid && !r_err && !r_write) ? w_ext : '0;

endmodule
